// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: owns the single 8-bit data-RAM port in the MEM stage.
// Scalar accesses pass straight through while idle. A 128-bit vector access
// is split into 16 byte beats, and the pipeline is stalled until it finishes.
// Optional feature macro: VMS_ALIGN_CHECK_EN. When it is defined, a vector
// base address that is not 16-byte aligned is rejected with a v_err pulse.
module vector_mem_sequencer #(
  parameter int ADDR_W = 16,
  parameter int LANES  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_req,
  input  logic                 s_we,
  input  logic [ADDR_W-1:0]    s_addr,
  input  logic [7:0]           s_wdata,
  output logic [7:0]           s_rdata,
  input  logic                 v_req,
  input  logic                 v_we,
  input  logic [ADDR_W-1:0]    v_addr,
  input  logic [LANES*8-1:0]   v_wdata,
  output logic [LANES*8-1:0]   v_rdata,
  output logic                 v_done,
  output logic                 v_err,
  output logic                 stall,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 ram_wren,
  input  logic [7:0]           ram_q
);

  typedef enum logic [1:0] {IDLE, VWRITE, VREAD, VDRAIN} state_e;

  localparam logic [3:0] LastBeat = 4'(LANES - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]    vbase_q, vbase_d;
  logic [LANES*8-1:0]   vbuf_q, vbuf_d;
  logic [LANES*8-1:0]   vrdata_q, vrdata_d;
  logic                 vdone_q, vdone_d;
  logic                 verr_q, verr_d;

  logic                 misaligned;
  logic [ADDR_W-1:0]    beatAddr;
  logic [3:0]           capLane;
  logic [ADDR_W-1:0]    ramAddr;
  logic [7:0]           ramWdata;
  logic                 ramWren;
  logic [7:0]           sRdata;
  logic                 busyStall;

`ifdef VMS_ALIGN_CHECK_EN
  assign misaligned = (v_addr[3:0] != 4'd0);
`else
  assign misaligned = 1'b0;
`endif

  // Beat address wraps modulo the address space; the read lane trails cnt by the RAM latency.
  assign beatAddr = vbase_q + ADDR_W'(cnt_q);
  assign capLane  = cnt_q - 4'(RD_LAT);

  // State register plus burst bookkeeping; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      vbase_q  <= '0;
      vbuf_q   <= '0;
      vrdata_q <= '0;
      vdone_q  <= 1'b0;
      verr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vbase_q  <= vbase_d;
      vbuf_q   <= vbuf_d;
      vrdata_q <= vrdata_d;
      vdone_q  <= vdone_d;
      verr_q   <= verr_d;
    end
  end

  // Next-state and RAM port mux: scalar passthrough while idle, vector beats otherwise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vbase_d   = vbase_q;
    vbuf_d    = vbuf_q;
    vrdata_d  = vrdata_q;
    vdone_d   = 1'b0;
    verr_d    = 1'b0;
    ramAddr   = s_addr;
    ramWdata  = s_wdata;
    ramWren   = s_req & s_we;
    sRdata    = ram_q;
    busyStall = v_req & ~vdone_q;
    case (state_q)
      IDLE: begin
        if (v_req && !s_req && !vdone_q) begin
          if (misaligned) begin
            vdone_d = 1'b1;
            verr_d  = 1'b1;
          end else begin
            vbase_d = v_addr;
            vbuf_d  = v_wdata;
            cnt_d   = 4'd0;
            state_d = v_we ? VWRITE : VREAD;
          end
        end
      end
      VWRITE: begin
        ramAddr   = beatAddr;
        ramWdata  = vbuf_q[{cnt_q, 3'b000} +: 8];
        ramWren   = 1'b1;
        sRdata    = 8'd0;
        busyStall = 1'b1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == LastBeat) begin
          state_d = IDLE;
          vdone_d = 1'b1;
        end
      end
      VREAD: begin
        ramAddr   = beatAddr;
        ramWdata  = 8'd0;
        ramWren   = 1'b0;
        sRdata    = 8'd0;
        busyStall = 1'b1;
        if (cnt_q != 4'd0) begin
          vrdata_d[{capLane, 3'b000} +: 8] = ram_q;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastBeat) begin
          state_d = VDRAIN;
        end
      end
      VDRAIN: begin
        ramAddr   = beatAddr;
        ramWdata  = 8'd0;
        ramWren   = 1'b0;
        sRdata    = 8'd0;
        busyStall = 1'b1;
        vrdata_d[{LastBeat, 3'b000} +: 8] = ram_q;
        cnt_d   = 4'd0;
        state_d = IDLE;
        vdone_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write enable and stall are forced low as soon as reset asserts, without waiting for a clock.
  assign ram_addr  = ramAddr;
  assign ram_wdata = ramWdata;
  assign ram_wren  = reset & ramWren;
  assign stall     = reset & busyStall;
  assign s_rdata   = sRdata;
  assign v_rdata   = vrdata_q;
  assign v_done    = vdone_q;
  assign v_err     = verr_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: drives scalar and vector traffic through the
// sequencer into a behavioural byte RAM. Expected RAM writes and expected
// vector load data are queued when stimulus is driven, then compared when
// the DUT produces them.
module tb_vector_mem_sequencer;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_req;
  logic          s_we;
  logic [15:0]   s_addr;
  logic [7:0]    s_wdata;
  logic [7:0]    s_rdata;
  logic          v_req;
  logic          v_we;
  logic [15:0]   v_addr;
  logic [127:0]  v_wdata;
  logic [127:0]  v_rdata;
  logic          v_done;
  logic          v_err;
  logic          stall;
  logic [15:0]   ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_wren;
  logic [7:0]    ram_q = 8'd0;

  logic [7:0]    mem [0:65535];
  logic [15:0]   expAddrQ[$];
  logic [7:0]    expDataQ[$];
  logic [127:0]  expVecQ[$];
  logic [127:0]  lastLoadVec = '0;

  int assertCount = 0;
  int failCount   = 0;

  vector_mem_sequencer #(.ADDR_W(16), .LANES(16), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata), .v_rdata(v_rdata),
    .v_done(v_done), .v_err(v_err), .stall(stall),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Byte RAM with one clock of registered read latency.
  always @(posedge clk) begin
    if (ram_wren === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  // Every RAM write seen mid-cycle must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && ram_wren === 1'b1) begin
      assertCount++;
      if (expAddrQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL ram_write_unexpected: got addr=%h data=%h, expected no write", ram_addr, ram_wdata);
      end else begin
        logic [15:0] ea;
        logic [7:0]  ed;
        ea = expAddrQ.pop_front();
        ed = expDataQ.pop_front();
        if (ram_addr !== ea || ram_wdata !== ed) begin
          failCount++;
          $display("[TB] FAIL ram_write: got addr=%h data=%h, expected addr=%h data=%h", ram_addr, ram_wdata, ea, ed);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWrite(input logic [15:0] a, input logic [7:0] d);
    expAddrQ.push_back(a);
    expDataQ.push_back(d);
  endtask

  task automatic pushVectorWrites(input logic [15:0] base, input logic [127:0] data);
    for (int k = 0; k < 16; k++) pushWrite(base + 16'(k), data[k*8 +: 8]);
  endtask

  // Holds a vector request from the current cycle until v_done; perturbs the
  // request fields and scalar inputs after accept, which the DUT must ignore.
  task automatic runVector(input logic we, input logic [15:0] addr, input logic [127:0] wdata,
                           output int doneCycle, output int stallCycles);
    v_req = 1'b1; v_we = we; v_addr = addr; v_wdata = wdata;
    #1;
    stallCycles = (stall === 1'b1) ? 1 : 0;
    doneCycle = 0;
    for (int c = 1; c <= 40 && doneCycle == 0; c++) begin
      tick();
      if (c == 1) begin
        v_addr = 16'h7777; v_wdata = ~wdata; v_we = ~we;
        s_req = 1'b1; s_we = 1'b1; s_addr = 16'hDEAD; s_wdata = 8'hEE;
      end
      if (c == 3) begin
        s_req = 1'b0; s_we = 1'b0;
      end
      #1;
      if (c == 5) begin
        assertCount++;
        if (s_rdata !== 8'd0) begin
          failCount++;
          $display("[TB] FAIL burst_s_rdata: got %h, expected %h", s_rdata, 8'd0);
        end
      end
      if (v_done === 1'b1) begin
        doneCycle = c;
        v_req = 1'b0;
      end else if (stall === 1'b1) begin
        stallCycles++;
      end
    end
    if (doneCycle == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL vector_timeout: got no v_done within 40 cycles, expected v_done");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    v_req = 1'b1; v_we = 1'b0; v_addr = '0; v_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    assertCount++;
    if (stall !== 1'b0) begin failCount++; $display("[TB] FAIL reset_stall: got %b, expected 0", stall); end
    assertCount++;
    if (ram_wren !== 1'b0) begin failCount++; $display("[TB] FAIL reset_wren: got %b, expected 0", ram_wren); end
    assertCount++;
    if (v_done !== 1'b0 || v_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done_err: got %b%b, expected 00", v_done, v_err); end
    assertCount++;
    if (v_rdata !== 128'd0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h, expected 0", v_rdata); end
    v_req = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    assertCount++;
    if (stall !== 1'b0) begin failCount++; $display("[TB] FAIL post_reset_stall: got %b, expected 0", stall); end
  endtask

  task automatic test_scalar();
    tick();
    s_req = 1'b1; s_we = 1'b1; s_addr = 16'h0040; s_wdata = 8'hA5;
    pushWrite(16'h0040, 8'hA5);
    #1;
    assertCount++;
    if (ram_wren !== 1'b1 || ram_addr !== 16'h0040 || stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL scalar_store: got wren=%b addr=%h stall=%b, expected 1 0040 0", ram_wren, ram_addr, stall);
    end
    tick();
    s_we = 1'b0;
    #1;
    assertCount++;
    if (ram_wren !== 1'b0 || stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL scalar_load_issue: got wren=%b stall=%b, expected 0 0", ram_wren, stall);
    end
    tick();
    s_req = 1'b0;
    #1;
    assertCount++;
    if (s_rdata !== 8'hA5 || stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL scalar_load_data: got %h stall=%b, expected a5 0", s_rdata, stall);
    end
  endtask

  task automatic test_vector_store();
    logic [127:0] vec;
    int done, st;
    for (int k = 0; k < 16; k++) vec[k*8 +: 8] = 8'(k);
    tick();
    pushVectorWrites(16'h0100, vec);
    runVector(1'b1, 16'h0100, vec, done, st);
    assertCount++;
    if (done != 17) begin failCount++; $display("[TB] FAIL store_done_cycle: got %0d, expected 17", done); end
    assertCount++;
    if (st != 17) begin failCount++; $display("[TB] FAIL store_stall_cycles: got %0d, expected 17", st); end
    tick();
    assertCount++;
    if (v_done !== 1'b0 || stall !== 1'b0) begin failCount++; $display("[TB] FAIL store_done_pulse: got done=%b stall=%b, expected 0 0", v_done, stall); end
    assertCount++;
    if (expAddrQ.size() != 0) begin failCount++; $display("[TB] FAIL store_write_count: got %0d missing, expected 0", expAddrQ.size()); end
  endtask

  task automatic test_vector_load();
    logic [127:0] exp, got;
    int done, st;
    for (int k = 0; k < 16; k++) exp[k*8 +: 8] = 8'(k);
    expVecQ.push_back(exp);
    tick();
    runVector(1'b0, 16'h0100, 128'd0, done, st);
    exp = expVecQ.pop_front();
    lastLoadVec = exp;
    got = v_rdata;
    assertCount++;
    if (got !== exp) begin failCount++; $display("[TB] FAIL load_data: got %h, expected %h", got, exp); end
    assertCount++;
    if (done != 18) begin failCount++; $display("[TB] FAIL load_done_cycle: got %0d, expected 18", done); end
    assertCount++;
    if (st != 18) begin failCount++; $display("[TB] FAIL load_stall_cycles: got %0d, expected 18", st); end
    tick();
    assertCount++;
    if (v_done !== 1'b0 || v_rdata !== exp) begin failCount++; $display("[TB] FAIL load_hold: got done=%b data=%h, expected 0 %h", v_done, v_rdata, exp); end
  endtask

  task automatic test_arbitration();
    logic [127:0] vec;
    int done, st;
    for (int k = 0; k < 16; k++) vec[k*8 +: 8] = 8'(8'h30 + k);
    tick();
    s_req = 1'b1; s_we = 1'b1; s_addr = 16'h0200; s_wdata = 8'h3C;
    v_req = 1'b1; v_we = 1'b1; v_addr = 16'h0300; v_wdata = vec;
    pushWrite(16'h0200, 8'h3C);
    pushVectorWrites(16'h0300, vec);
    #1;
    assertCount++;
    if (ram_wren !== 1'b1 || ram_addr !== 16'h0200 || stall !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL arb_scalar_first: got wren=%b addr=%h stall=%b, expected 1 0200 1", ram_wren, ram_addr, stall);
    end
    tick();
    s_req = 1'b0; s_we = 1'b0;
    runVector(1'b1, 16'h0300, vec, done, st);
    assertCount++;
    if (done != 17) begin failCount++; $display("[TB] FAIL arb_done_cycle: got %0d, expected 17", done); end
    tick();
    assertCount++;
    if (expAddrQ.size() != 0) begin failCount++; $display("[TB] FAIL arb_write_count: got %0d missing, expected 0", expAddrQ.size()); end
  endtask

`ifdef VMS_ALIGN_CHECK_EN
  task automatic test_align();
    tick();
    v_req = 1'b1; v_we = 1'b1; v_addr = 16'h0103; v_wdata = {16{8'hFF}};
    #1;
    assertCount++;
    if (stall !== 1'b1) begin failCount++; $display("[TB] FAIL align_req_stall: got %b, expected 1", stall); end
    tick();
    #1;
    assertCount++;
    if (v_done !== 1'b1 || v_err !== 1'b1 || stall !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL align_err: got done=%b err=%b stall=%b, expected 1 1 0", v_done, v_err, stall);
    end
    v_req = 1'b0;
    tick();
    assertCount++;
    if (v_done !== 1'b0 || v_err !== 1'b0 || v_rdata !== lastLoadVec) begin
      failCount++;
      $display("[TB] FAIL align_after: got done=%b err=%b data=%h, expected 0 0 %h", v_done, v_err, v_rdata, lastLoadVec);
    end
  endtask
`else
  task automatic test_wrap();
    logic [127:0] vec;
    int done, st;
    for (int k = 0; k < 16; k++) vec[k*8 +: 8] = 8'(8'hA0 + k);
    tick();
    pushVectorWrites(16'hFFF8, vec);
    runVector(1'b1, 16'hFFF8, vec, done, st);
    assertCount++;
    if (done != 17) begin failCount++; $display("[TB] FAIL wrap_done_cycle: got %0d, expected 17", done); end
    tick();
    assertCount++;
    if (expAddrQ.size() != 0) begin failCount++; $display("[TB] FAIL wrap_write_count: got %0d missing, expected 0", expAddrQ.size()); end
  endtask
`endif

  task automatic test_reset_mid_burst();
    logic [127:0] vec;
    bit sawDone;
    for (int k = 0; k < 16; k++) vec[k*8 +: 8] = 8'(8'h50 + k);
    for (int k = 0; k < 7; k++) pushWrite(16'h0500 + 16'(k), vec[k*8 +: 8]);
    tick();
    v_req = 1'b1; v_we = 1'b1; v_addr = 16'h0500; v_wdata = vec;
    repeat (8) tick();
    #1;
    assertCount++;
    if (stall !== 1'b1 || ram_wren !== 1'b1 || ram_addr !== 16'h0507) begin
      failCount++;
      $display("[TB] FAIL midburst_beat7: got stall=%b wren=%b addr=%h, expected 1 1 0507", stall, ram_wren, ram_addr);
    end
    reset = 1'b0; v_req = 1'b0;
    #1;
    assertCount++;
    if (ram_wren !== 1'b0 || stall !== 1'b0 || v_rdata !== 128'd0) begin
      failCount++;
      $display("[TB] FAIL midburst_reset: got wren=%b stall=%b data=%h, expected 0 0 0", ram_wren, stall, v_rdata);
    end
    repeat (2) tick();
    reset = 1'b1;
    sawDone = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      #1;
      if (v_done === 1'b1) sawDone = 1'b1;
    end
    assertCount++;
    if (sawDone) begin failCount++; $display("[TB] FAIL midburst_no_done: got v_done pulse, expected none"); end
    assertCount++;
    if (expAddrQ.size() != 0) begin failCount++; $display("[TB] FAIL midburst_writes: got %0d missing, expected 0", expAddrQ.size()); end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'd0;
    test_reset();
    test_scalar();
    test_vector_store();
    test_vector_load();
    test_arbitration();
`ifdef VMS_ALIGN_CHECK_EN
    test_align();
`else
    test_wrap();
`endif
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
Sequences all accesses to the single 8-bit data-RAM port in the MEM stage. Scalar loads and stores pass through in one cycle. A 128-bit vector load or store is split into 16 byte beats on the same port, and the pipeline is stalled until the transfer completes. Sits between the ExecuteMemory register outputs and the RAM. It replaces direct RAM wiring for vector traffic.

Parameters:
ADDR_W, 16, data-RAM byte address width
LANES, 16, bytes per vector register (vector width = LANES*8)
RD_LAT, 1, RAM read latency in clocks; fixed at 1 (registered q)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
s_req  in  1  scalar access request from MEM stage
s_we  in  1  scalar write (1) / read (0)
s_addr  in  ADDR_W  scalar byte address
s_wdata  in  8  scalar store data
s_rdata  out  8  scalar load data (RAM q, passthrough)
v_req  in  1  vector access request; held high until v_done
v_we  in  1  vector store (1) / load (0)
v_addr  in  ADDR_W  vector base byte address
v_wdata  in  LANES*8  vector store data; lane k = bits [8k+7:8k]
v_rdata  out  LANES*8  assembled vector load data
v_done  out  1  one-cycle completion pulse
v_err  out  1  one-cycle misalignment pulse (see Optional Feature)
stall  out  1  freeze IF/ID/EX/MEM registers
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  8  RAM write data
ram_wren  out  1  RAM write enable
ram_q  in  8  RAM read data, valid RD_LAT cycles after address

Behaviour:
- States: IDLE, VWRITE, VREAD, VDRAIN. Beat counter cnt is 4 bits. Latched base is vbase; latched store data is vbuf.
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, vbase=0, vbuf=0, v_rdata=0, v_done=0, v_err=0. ram_wren=0 and stall=0 take effect immediately.
- IDLE, per cycle:
  - ram_addr=s_addr, ram_wdata=s_wdata, ram_wren=s_req&s_we.
  - s_rdata=ram_q.
- Arbitration in IDLE: a scalar request has priority in the same cycle.
  - If s_req and v_req are both high, the scalar beat is issued that cycle.
  - The vector request is accepted at the next edge where s_req=0.
- Vector accept: at a rising edge in IDLE with v_req=1, s_req=0 and v_done=0.
  - Latch vbase=v_addr and vbuf=v_wdata; clear cnt.
  - Go to VWRITE if v_we=1, otherwise VREAD.
- stall = (state!=IDLE) | (v_req & ~v_done & state==IDLE). stall is combinational, so the pipeline freezes in the request cycle.
- VWRITE:
  - ram_addr=vbase+cnt (mod 2^ADDR_W; wraps at top of memory), ram_wdata=vbuf lane cnt, ram_wren=1, cnt++.
  - At the edge with cnt=15: go to IDLE and register v_done=1.
  - Result: v_done is high in the 17th cycle after the accept edge; 16 RAM writes in total.
- VREAD:
  - ram_addr=vbase+cnt, ram_wren=0.
  - From the second beat on, each edge captures ram_q into lane cnt-1 of v_rdata.
  - At the edge with cnt=15: go to VDRAIN.
- VDRAIN: ram_wren=0; the edge captures lane 15, goes to IDLE and registers v_done=1. v_done is high in the 18th cycle after the accept edge.
- v_done lasts exactly one cycle. v_rdata holds its value until the next vector load completes or reset.
- The requester drops v_req in the v_done cycle. If v_req is still high the cycle after v_done, it is treated as a new request.
- Outside IDLE: s_rdata=0 and scalar inputs are ignored (the MEM stage is stalled).
- Signal changes on v_addr, v_we or v_wdata after accept are ignored, because the values are latched.
- Reset asserted mid-burst: the burst is aborted, any partially written vector remains in RAM, and no v_done is produced.

Optional Feature:
VMS_ALIGN_CHECK_EN
- Defined: at accept, if v_addr[3:0]!=0, no RAM beat is issued. The block registers v_err=1 and v_done=1 for one cycle, then returns to IDLE; v_rdata is unchanged.
- Undefined: v_err is tied 0 and any base address is accepted, wrapping per byte.

Test Plan:
- Scalar store then load: s_req=1, s_we=1, s_addr=0x0040, s_wdata=0xA5, then a read of 0x0040 -> ram_wren for 1 cycle, s_rdata=0xA5 one cycle later, stall=0 throughout.
- Vector store: v_addr=0x0100, v_wdata lanes = 0x00..0x0F -> 16 consecutive writes to 0x0100..0x010F, stall high for 17 cycles, v_done pulses once.
- Vector load of the same data -> v_rdata=0x0F0E...0100, v_done in the 18th cycle after accept.
- Simultaneous s_req and v_req -> scalar beat issued first, vector accepted the next cycle.
- Wrap-around: v_addr=0xFFF8 -> beats 0xFFF8..0xFFFF then 0x0000..0x0007 (run with the macro undefined).
- Reset pulse at beat 7 of a vector store -> state returns to IDLE, ram_wren=0 and stall=0 immediately, v_done never asserts. With VMS_ALIGN_CHECK_EN defined, v_addr=0x0103 -> v_err=v_done=1 one cycle after accept, no RAM writes.
